wb_arbiter: RTL

Writeback arbiter that shares the single register-file write port between several writeback producers (EXU result path, LSU load-return path, etc.). Each producer offers a `{addr, data}` payload over a valid/ready stage handshake. The arbiter grants one producer per cycle with round-robin fairness, registers the winner, and drives the register file's write-feedback port (`wen/addr/data`) one cycle later. It sits between the last pipeline stages and the regfile, replacing direct producer-to-regfile wiring.

---
 rtl/wb_arbiter.sv | 56 +++++
 1 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter driving a registered regfile write port
module wb_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*5-1:0]       req_addr,
  input  logic [NUM_REQ*32-1:0]      req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       flush,
  output logic                       rf_wen,
  output logic [4:0]                 rf_addr,
  output logic [31:0]                rf_data,
  output logic [$clog2(NUM_REQ)-1:0] rf_src
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0] ptr, win, j;
  logic any, fire, wen_n;
  logic [4:0] fa;
  logic [31:0] fd;
  // scan from ptr downwards in priority so the first valid after ptr wins
  always_comb begin
    win = ptr;
    any = 1'b0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = PW'((int'(ptr) + k) % NUM_REQ);
      if (req_valid[j]) begin
        win = j;
        any = 1'b1;
      end
    end
  end
  assign fire = any && !flush && !rst;
  assign req_ready = fire ? NUM_REQ'(1) << win : '0;
  assign fa = req_addr[int'(win)*5 +: 5];
  assign fd = req_data[int'(win)*32 +: 32];
  assign wen_n = fire && fa != 5'd0;
  // capture the fired payload; x0 writes are consumed but never enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      rf_wen <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
      rf_src <= '0;
    end else begin
      ptr <= fire ? PW'((int'(win) + 1) % NUM_REQ) : ptr;
      rf_wen <= wen_n;
      rf_addr <= wen_n ? fa : 5'd0;
      rf_data <= wen_n ? fd : 32'd0;
      rf_src <= fire ? win : '0;
    end
  end
endmodule
